// File: rtl/mesh_switch_allocator_pkg.sv
// rtl/mesh_switch_allocator_pkg.sv - shared MESH router types, port indices and width helpers
package mesh_switch_allocator_pkg;

    localparam int MESH_PORTS = 5;
    localparam int PORT_LOCAL = 0;
    localparam int PORT_NORTH = 1;
    localparam int PORT_EAST  = 2;
    localparam int PORT_SOUTH = 3;
    localparam int PORT_WEST  = 4;

    localparam int PAYLOAD_W  = 32;

    typedef struct packed {
        logic [2:0]           dest;
        logic [PAYLOAD_W-1:0] payload;
    } packet_t;

    function automatic int credit_cnt_w(input int credits);
        return $clog2(credits + 1);
    endfunction

    function automatic int ptr_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mesh_rr_arbiter.sv
// rtl/mesh_rr_arbiter.sv - N-way round-robin arbiter with registered pointer and enable
module mesh_rr_arbiter
    import mesh_switch_allocator_pkg::*;
#(
    parameter int N = 5
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_en,
    input  logic [N-1:0] i_req,
    output logic [N-1:0] o_gnt
);

    localparam int PW = ptr_w(N);

    logic [PW-1:0] r_ptr;
    logic [PW-1:0] w_ptr_next;
    logic [PW-1:0] w_idx;
    logic          w_hit;

    // Search starts at the pointer and wraps; first requester wins.
    always_comb begin
        o_gnt      = '0;
        w_ptr_next = r_ptr;
        w_hit      = 1'b0;
        w_idx      = '0;
        for (int i = 0; i < N; i++) begin
            w_idx = PW'((int'(r_ptr) + i) % N);
            if (i_en && !w_hit && i_req[w_idx]) begin
                o_gnt[w_idx] = 1'b1;
                w_hit        = 1'b1;
                w_ptr_next   = PW'((int'(w_idx) + 1) % N);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ptr <= '0;
        end else begin
            r_ptr <= w_ptr_next;
        end
    end

endmodule

// File: rtl/mesh_switch_allocator.sv
// rtl/mesh_switch_allocator.sv - credit-gated round-robin switch allocator driving the 5x5 crossbar
module mesh_switch_allocator
    import mesh_switch_allocator_pkg::*;
#(
    parameter int N       = 5,
    parameter int M       = 5,
    parameter int CREDITS = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [0:N-1][M-1:0]   i_req,
    input  logic [0:M-1]          i_credit,
    output logic [0:N-1]          o_grant,
    output logic [0:M-1][N-1:0]   o_sel,
    output logic [0:M-1]          o_valid,
    output logic [0:M-1]          o_credit_err
);

    localparam int CW = credit_cnt_w(CREDITS);

    logic [CW-1:0] r_cnt [M];
    logic [0:M-1]  r_err;
    logic [N-1:0]  w_col [M];
    logic [N-1:0]  w_gnt [M];

    // Only the MSB (lowest output index) of a multi-bit request counts.
    always_comb begin
        for (int k = 0; k < M; k++) begin
            w_col[k] = '0;
        end
        for (int j = 0; j < N; j++) begin
            for (int k = M - 1; k >= 0; k--) begin
                if (i_req[j][M-1-k]) begin
                    for (int kk = 0; kk < M; kk++) begin
                        w_col[kk][j] = (kk == k);
                    end
                end
            end
        end
    end

    for (genvar k = 0; k < M; k++) begin : g_arb
        mesh_rr_arbiter #(.N(N)) u_arb (
            .clk   (clk),
            .reset (reset),
            .i_en  (!reset && (r_cnt[k] != '0)),
            .i_req (w_col[k]),
            .o_gnt (w_gnt[k])
        );
    end

    always_comb begin
        o_grant = '0;
        for (int k = 0; k < M; k++) begin
            o_valid[k] = |w_gnt[k];
            for (int j = 0; j < N; j++) begin
                o_sel[k][N-1-j] = w_gnt[k][j];
                o_grant[j]      = o_grant[j] | w_gnt[k][j];
            end
        end
    end

    // A credit into a full counter is dropped and flagged for one cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < M; k++) begin
                r_cnt[k] <= CW'(CREDITS);
            end
            r_err <= '0;
        end else begin
            for (int k = 0; k < M; k++) begin
                if (i_credit[k] && !o_valid[k] && (r_cnt[k] == CW'(CREDITS))) begin
                    r_err[k] <= 1'b1;
                end else begin
                    r_err[k] <= 1'b0;
                    r_cnt[k] <= r_cnt[k] - CW'(o_valid[k]) + CW'(i_credit[k]);
                end
            end
        end
    end

    assign o_credit_err = r_err;

endmodule

// File: tb/tb_mesh_switch_allocator.sv
// tb/tb_mesh_switch_allocator.sv - directed and random checks of mesh_switch_allocator against a reference model
module tb_mesh_switch_allocator;

    localparam int N = 5;
    localparam int M = 5;
    localparam int CREDITS = 4;

    logic                clk = 1'b0;
    logic                reset;
    logic [0:N-1][M-1:0] i_req;
    logic [0:M-1]        i_credit;
    logic [0:N-1]        o_grant;
    logic [0:M-1][N-1:0] o_sel;
    logic [0:M-1]        o_valid;
    logic [0:M-1]        o_credit_err;

    mesh_switch_allocator #(.N(N), .M(M), .CREDITS(CREDITS)) dut (
        .clk          (clk),
        .reset        (reset),
        .i_req        (i_req),
        .i_credit     (i_credit),
        .o_grant      (o_grant),
        .o_sel        (o_sel),
        .o_valid      (o_valid),
        .o_credit_err (o_credit_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    int m_ptr [M];
    int m_cnt [M];
    int m_err [M];
    int m_win [M];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < M; k++) begin
            m_ptr[k] = 0;
            m_cnt[k] = CREDITS;
            m_err[k] = 0;
        end
    endtask

    // Winner for output k = requester closest at or after ptr[k] in circular distance.
    task automatic apply_check();
        int dest [N];
        int best, bestd, d;
        logic [N-1:0] exp_sel;
        logic exp_g;
        #1;
        for (int j = 0; j < N; j++) begin
            dest[j] = -1;
            for (int k = M - 1; k >= 0; k--)
                if (i_req[j][M-1-k]) dest[j] = k;
        end
        for (int k = 0; k < M; k++) begin
            best  = -1;
            bestd = N;
            if (!reset && m_cnt[k] > 0) begin
                for (int j = 0; j < N; j++) begin
                    d = (j - m_ptr[k] + N) % N;
                    if (dest[j] == k && d < bestd) begin
                        bestd = d;
                        best  = j;
                    end
                end
            end
            m_win[k] = best;
            exp_sel  = (best >= 0) ? (N'(1) << (N - 1 - best)) : '0;
            chk($sformatf("sel[%0d]", k), 32'(o_sel[k]), 32'(exp_sel));
            chk($sformatf("valid[%0d]", k), 32'(o_valid[k]), 32'(best >= 0));
            chk($sformatf("credit_err[%0d]", k), 32'(o_credit_err[k]), 32'(m_err[k]));
        end
        for (int j = 0; j < N; j++) begin
            exp_g = 1'b0;
            for (int k = 0; k < M; k++)
                if (m_win[k] == j) exp_g = 1'b1;
            chk($sformatf("grant[%0d]", j), 32'(o_grant[j]), 32'(exp_g));
        end
    endtask

    task automatic advance();
        int g;
        @(posedge clk);
        if (reset) begin
            model_reset();
        end else begin
            for (int k = 0; k < M; k++) begin
                g = (m_win[k] >= 0) ? 1 : 0;
                if (g == 1) m_ptr[k] = (m_win[k] + 1) % N;
                if (i_credit[k] && g == 0 && m_cnt[k] == CREDITS) begin
                    m_err[k] = 1;
                end else begin
                    m_err[k] = 0;
                    m_cnt[k] = m_cnt[k] - g + int'(i_credit[k]);
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        for (int j = 0; j < N; j++) i_req[j] = '0;
        i_credit = '0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        model_reset();
        apply_check();
        advance();
        reset = 1'b0;
    endtask

    task automatic drive_s2();
        clear_inputs();
        i_req[0] = 5'b01000;
        i_req[1] = 5'b01000;
        i_req[3] = 5'b01000;
        i_credit[1] = 1'b1;
    endtask

    logic [N-1:0] s2_sel [3];
    int r;

    initial begin
        s2_sel[0] = 5'b10000;
        s2_sel[1] = 5'b01000;
        s2_sel[2] = 5'b00010;
        clear_inputs();
        reset = 1'b1;
        model_reset();
        @(negedge clk);
        do_reset();

        // Scenario 1: single request
        clear_inputs();
        i_req[2] = 5'b10000;
        apply_check();
        chk("s1_sel0", 32'(o_sel[0]), 32'h04);
        chk("s1_grant2", 32'(o_grant[2]), 32'h1);
        advance();

        // Scenario 2: three-way contention with continuous credit return
        drive_s2();
        for (int i = 0; i < 6; i++) begin
            apply_check();
            chk("s2_sel1", 32'(o_sel[1]), 32'(s2_sel[i % 3]));
            advance();
        end

        // Scenario 3: credit exhaustion then one credit
        clear_inputs();
        i_req[4] = 5'b00100;
        for (int i = 0; i < 6; i++) begin
            apply_check();
            advance();
        end
        i_credit[2] = 1'b1;
        apply_check();
        advance();
        i_credit[2] = 1'b0;
        for (int i = 0; i < 2; i++) begin
            apply_check();
            advance();
        end

        // Scenario 4: grant and credit in the same cycle at cnt=1
        clear_inputs();
        i_req[0] = 5'b00010;
        for (int i = 0; i < 3; i++) begin
            apply_check();
            advance();
        end
        i_credit[3] = 1'b1;
        apply_check();
        advance();
        i_credit[3] = 1'b0;
        for (int i = 0; i < 2; i++) begin
            apply_check();
            advance();
        end

        // Scenario 5: overflowing credit
        do_reset();
        clear_inputs();
        i_credit[0] = 1'b1;
        apply_check();
        advance();
        i_credit[0] = 1'b0;
        apply_check();
        chk("s5_err_set", 32'(o_credit_err[0]), 32'h1);
        advance();
        apply_check();
        chk("s5_err_clr", 32'(o_credit_err[0]), 32'h0);
        advance();

        // Scenario 6: asynchronous reset under traffic
        do_reset();
        drive_s2();
        for (int i = 0; i < 4; i++) begin
            apply_check();
            advance();
        end
        apply_check();
        #2;
        reset = 1'b1;
        model_reset();
        apply_check();
        chk("s6_grant", 32'(o_grant), 32'h0);
        advance();
        reset = 1'b0;
        apply_check();
        chk("s6_first", 32'(o_sel[1]), 32'h10);
        advance();

        // Random traffic
        for (int c = 0; c < 400; c++) begin
            for (int j = 0; j < N; j++) begin
                r = $urandom_range(0, 9);
                if (r < 3)      i_req[j] = '0;
                else if (r < 8) i_req[j] = 5'(1 << $urandom_range(0, 4));
                else            i_req[j] = 5'($urandom);
            end
            for (int k = 0; k < M; k++) i_credit[k] = ($urandom_range(0, 2) == 0);
            apply_check();
            if (c == 200) begin
                #2;
                reset = 1'b1;
                model_reset();
                apply_check();
            end
            advance();
            reset = 1'b0;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
